// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester add/sub arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Combinational two's-complement adder/subtractor, subtraction as a + ~b + 1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module adder_arbiter_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] carry_in;

    assign b_eff    = subtract ? ~b : b;
    assign carry_in = {{(WIDTH-1){1'b0}}, subtract};
    assign result   = a + b_eff + carry_in;

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; round-robin grant, result held until consumed.
// Latency: ready cycle -> resp_valid two cycles later; one op per 3 cycles at best.
// Backpressure: DONE holds result/overflow until resp_ready; readies low outside IDLE.
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_calc;
    logic             gnt;

    adder_arbiter_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a       (a_q),
        .b       (b_q),
        .subtract(sub_q),
        .result  (sum)
    );

    // Overflow: operands of equal sign producing a result of the other sign.
    assign b_eff    = sub_q ? ~b_q : b_q;
    assign ovf_calc = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    // Grant choice: contention goes to whoever was not served last.
    always_comb begin
        gnt = REQ_ID0;
        if (req0_valid && req1_valid) begin
            gnt = (last_q == REQ_ID1) ? REQ_ID0 : REQ_ID1;
        end else if (req1_valid) begin
            gnt = REQ_ID1;
        end
    end

    // Next-state, operand capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        owner_d    = owner_q;
        last_d     = last_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_d    = gnt;
                    last_d     = gnt;
                    a_d        = (gnt == REQ_ID1) ? req1_a   : req0_a;
                    b_d        = (gnt == REQ_ID1) ? req1_b   : req0_b;
                    sub_d      = (gnt == REQ_ID1) ? req1_sub : req0_sub;
                    req0_ready = (gnt == REQ_ID0);
                    req1_ready = (gnt == REQ_ID1);
                    state_d    = CALC;
                end
            end
            CALC: begin
                result_d = sum;
                ovf_d    = ovf_calc;
                state_d  = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            owner_q  <= REQ_ID0;
            last_q   <= REQ_ID1;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign resp0_valid = (state_q == DONE) && (owner_q == REQ_ID0);
    assign resp1_valid = (state_q == DONE) && (owner_q == REQ_ID1);
    assign result      = result_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: scoreboard of accepted ops vs responses.
// Latency: checks resp_valid two cycles after the ready cycle.
// Backpressure: exercises resp_ready held low and reset mid-operation.
module tb_adder_arbiter;

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic        ovf;
        logic [31:0] acc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_sub, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_sub, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic        resp_rdy;
    logic [31:0] result;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_rdy0 = 0, n_rdy1 = 0, n_resp0 = 0, n_resp1 = 0;
    logic        prev_rdy = 1'b0;
    logic        prev_resp = 1'b0;
    exp_t        sb[$];
    logic        log_owner[$];
    logic [31:0] log_res[$];
    logic        log_ovf[$];

    adder_arbiter #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .req1_ready (req1_ready),
        .resp0_valid(resp0_valid),
        .resp1_valid(resp1_valid),
        .resp_ready (resp_rdy),
        .result     (result),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference arithmetic done in wide signed integers.
    function automatic exp_t model(input logic owner, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input int acc);
        exp_t   m;
        longint sa, sb_v, full, hi, lo;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        full = sub ? (sa - sb_v) : (sa + sb_v);
        hi   = longint'(32'sh7FFFFFFF);
        lo   = -hi - 1;
        m.owner = owner;
        m.res   = full[31:0];
        m.ovf   = (full > hi) || (full < lo);
        m.acc   = 32'(acc);
        return m;
    endfunction

    // Monitor: push on ready, compare on response, pop on consumption.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (reset_n) begin
            if (req0_ready || req1_ready) begin
                check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
                check("ready_pulse", 32'(prev_rdy), 32'd0);
                if (req0_ready) begin
                    n_rdy0++;
                    sb.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
                end else begin
                    n_rdy1++;
                    sb.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
                end
            end
            if (resp0_valid) n_resp0++;
            if (resp1_valid) n_resp1++;
            if (resp0_valid || resp1_valid) begin
                check("resp_onehot", 32'(resp0_valid & resp1_valid), 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    check("resp_owner", 32'(resp1_valid), 32'(e.owner));
                    check("result", result, e.res);
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    if (!prev_resp) check("latency", 32'(cyc) - e.acc, 32'd2);
                    if (resp_rdy) begin
                        void'(sb.pop_front());
                        log_owner.push_back(resp1_valid);
                        log_res.push_back(result);
                        log_ovf.push_back(overflow);
                    end
                end
            end
        end
        prev_rdy  = req0_ready | req1_ready;
        prev_resp = resp0_valid | resp1_valid;
    end

    task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic got = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            got = id ? req1_ready : req0_ready;
        end
        check("accepted", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            done = (sb.size() == 0);
        end
        check("drained", 32'(done), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log_owner.delete();
        log_res.delete();
        log_ovf.delete();
        n_rdy0 = 0; n_rdy1 = 0; n_resp0 = 0; n_resp1 = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        resp_rdy = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single requester 0: 25 + 40.
        clear_logs();
        drive(1'b0, 32'd25, 32'd40, 1'b0);
        drain();
        check("r27_count", 32'(log_res.size()), 32'd1);
        check("r27_ready_pulses", 32'(n_rdy0), 32'd1);
        check("r27_result", log_res[0], 32'd65);
        check("r27_ovf", 32'(log_ovf[0]), 32'd0);
        check("r27_no_resp1", 32'(n_resp1), 32'd0);

        // Single requester 1: -50 - (-10).
        clear_logs();
        drive(1'b1, 32'hFFFF_FFCE, 32'hFFFF_FFF6, 1'b1);
        drain();
        check("r28_result", log_res[0], 32'hFFFF_FFD8);
        check("r28_owner", 32'(log_owner[0]), 32'd1);
        check("r28_no_resp0", 32'(n_resp0), 32'd0);

        // Simultaneous after reset: requester 0 wins first.
        pulse_reset();
        clear_logs();
        fork
            drive(1'b0, 32'hFFFF_FFF4, 32'd25, 1'b0);
            drive(1'b1, 32'd25, 32'd40, 1'b1);
        join
        drain();
        check("r29_count", 32'(log_res.size()), 32'd2);
        check("r29_first_owner", 32'(log_owner[0]), 32'd0);
        check("r29_first_result", log_res[0], 32'd13);
        check("r29_second_owner", 32'(log_owner[1]), 32'd1);
        check("r29_second_result", log_res[1], 32'hFFFF_FFF1);

        // Continuous contention: grants alternate.
        clear_logs();
        fork
            begin
                for (int i = 0; i < 3; i++) drive(1'b0, 32'(i * 7 + 1), 32'(i), 1'b0);
            end
            begin
                for (int j = 0; j < 3; j++) drive(1'b1, 32'(100 + j), 32'd3, 1'b1);
            end
        join
        drain();
        check("r30_count", 32'(log_owner.size()), 32'd6);
        for (int k = 0; k < 6; k++) check("r30_grant", 32'(log_owner[k]), 32'(k % 2));

        // Overflow boundaries.
        clear_logs();
        drive(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        drive(1'b1, 32'h8000_0000, 32'd1, 1'b1);
        drain();
        check("r31_add_result", log_res[0], 32'h8000_0000);
        check("r31_add_ovf", 32'(log_ovf[0]), 32'd1);
        check("r31_sub_result", log_res[1], 32'h7FFF_FFFF);
        check("r31_sub_ovf", 32'(log_ovf[1]), 32'd1);

        // Random operations, checked by the scoreboard model.
        for (int r = 0; r < 8; r++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        // Hold result under resp_ready low, then reset during CALC.
        clear_logs();
        resp_rdy = 1'b0;
        drive(1'b0, 32'd100, 32'd23, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = resp0_valid;
        end
        check("r32_resp_seen", 32'(seen), 32'd1);
        held = result;
        check("r32_value", held, 32'd123);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("r32_hold_result", result, held);
            check("r32_hold_valid", 32'(resp0_valid), 32'd1);
        end
        @(posedge clock);
        #1;
        resp_rdy = 1'b1;
        drain();
        check("r32_consumed", 32'(log_res.size()), 32'd1);

        req1_a = 32'd5; req1_b = 32'd6; req1_sub = 1'b0; req1_valid = 1'b1;
        @(negedge clock);
        check("r32_second_accept", 32'(req1_ready), 32'd1);
        @(posedge clock);
        #1;
        req1_valid = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("r32_post_rst_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
            check("r32_post_rst_result", result, 32'd0);
            check("r32_post_rst_ovf", 32'(overflow), 32'd0);
        end
        @(posedge clock);
        #1;
        req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0; req0_valid = 1'b1;
        @(negedge clock);
        check("r32_idle_ready", 32'(req0_ready), 32'd1);
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands, two's complement.
REQ-006 req0_sub  input  1  requester 0 operation select: 1 = a-b, 0 = a+b.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_sub, req1_ready: same as REQ-004..007 for requester 1.
REQ-009 resp0_valid, resp1_valid  output  1 each  result held for requester 0 / 1.
REQ-010 resp_ready  input  1  the responding requester consumes the result this cycle.
REQ-011 result  output  WIDTH  registered sum or difference.
REQ-012 overflow  output  1  registered signed-overflow flag for result.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 IDLE: a requester is accepted when its valid is high; its ready pulses for exactly one cycle; its operands, sub and owner id are latched; next state CALC.
REQ-015 Both valid in IDLE: grant goes to the requester not granted last (round-robin); the loser's ready stays low and its inputs stay held.
REQ-016 CALC: the latched operands drive the single shared adder; result and overflow are registered; next state DONE.
REQ-017 DONE: only the owner's resp_valid is high; result and overflow are held stable until resp_ready is high, then next state IDLE.
REQ-018 Latency: acceptance at edge N, resp_valid high after edge N+2; maximum throughput is one operation per 3 cycles.
REQ-019 Both ready outputs SHALL be low in CALC and DONE; valid inputs in those states are ignored.
REQ-020 Arithmetic is modulo 2^WIDTH; subtraction is a + ~b + 1.
REQ-021 overflow = 1 iff a and the effective b (b, or ~b when subtracting) have equal sign bits and the result sign differs from them.
REQ-022 At most one of resp0_valid and resp1_valid is high in any cycle.

Reset
REQ-023 reset_n low at a rising edge SHALL force state IDLE, all ready and resp_valid low, result 0, overflow 0, last grant = requester 1, from any state.
REQ-024 An operation in CALC or DONE when reset is taken is discarded; no response is produced.

Structure
REQ-025 The FSM state encoding and the requester id constants SHALL be in shared package alu_pkg.
REQ-026 The arithmetic SHALL be one instance of the existing combinational adder (a, b, subtract, result); there are no other sub-modules.

Verification
REQ-027 req0 alone, a=25, b=40, sub=0 -> req0_ready pulses once, resp0_valid high two cycles later, result=65, overflow=0.
REQ-028 req1 alone, a=-50, b=-10, sub=1 -> result=-40, resp1_valid only, resp0_valid stays 0.
REQ-029 req0 and req1 valid simultaneously after reset (req0 -12+25, req1 25-40) -> req0 served first, result 13; then req1 served, result -15.
REQ-030 Both requesters continuously valid for 6 operations -> grants strictly alternate 0,1,0,1,0,1.
REQ-031 a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1; a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, overflow=1.
REQ-032 resp_ready held low 5 cycles in DONE, then reset_n pulsed low during a later CALC -> result held stable for all 5 cycles; after reset: state IDLE, result=0, no resp_valid.
